// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/JALR operand hazard resolver: tracks in-flight writers in EX/MEM
// shadow slots and picks register file, MEM-stage forward, or stall for the branch mux.
module branch_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic             id_is_branch_i,
    input  logic             id_is_jalr_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  mem_alu_result_i,
    output logic [1:0]       update_o,
    output logic [XLEN-1:0]  forward_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_count_o
);

    logic            ex_v_q, ex_wr_q, ex_ld_q;
    logic [RA_W-1:0] ex_rd_q;
    logic            mem_v_q, mem_wr_q, mem_ld_q;
    logic [RA_W-1:0] mem_rd_q;
    logic [CNT_W-1:0] stall_count_q;

    logic use1, use2;
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic stall_raw;
    logic [1:0] update_d;
    logic [XLEN-1:0] forward_d;

    // x0 is hardwired, so a used source of x0 never matches a producer.
    assign use1 = id_valid_i & (id_is_branch_i | id_is_jalr_i) & (id_rs1_i != '0);
    assign use2 = id_valid_i & id_is_branch_i & (id_rs2_i != '0);

    assign ex_hit1  = use1 & ex_v_q  & ex_wr_q  & (ex_rd_q  == id_rs1_i);
    assign ex_hit2  = use2 & ex_v_q  & ex_wr_q  & (ex_rd_q  == id_rs2_i);
    assign mem_hit1 = use1 & mem_v_q & mem_wr_q & (mem_rd_q == id_rs1_i);
    assign mem_hit2 = use2 & mem_v_q & mem_wr_q & (mem_rd_q == id_rs2_i);

    // Both sources hitting MEM needs two forward paths; the mux only has one.
    assign stall_raw = ex_hit1 | ex_hit2
                     | ((mem_hit1 | mem_hit2) & mem_ld_q)
                     | (mem_hit1 & mem_hit2);

    always_comb begin
        update_d  = 2'b00;
        forward_d = '0;
        if (!stall_raw && !flush_i) begin
            if (mem_hit1) begin
                update_d  = 2'b01;
                forward_d = mem_alu_result_i;
            end else if (mem_hit2) begin
                update_d  = 2'b10;
                forward_d = mem_alu_result_i;
            end
        end
    end

    assign stall_o       = stall_raw & ~flush_i;
    assign update_o      = update_d;
    assign forward_o     = forward_d;
    assign stall_count_o = stall_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex_v_q        <= 1'b0;
            ex_wr_q       <= 1'b0;
            ex_ld_q       <= 1'b0;
            ex_rd_q       <= '0;
            mem_v_q       <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_ld_q      <= 1'b0;
            mem_rd_q      <= '0;
            stall_count_q <= '0;
        end else begin
            mem_v_q  <= ex_v_q;
            mem_wr_q <= ex_wr_q;
            mem_ld_q <= ex_ld_q;
            mem_rd_q <= ex_rd_q;
            if (id_valid_i && !stall_o && !flush_i) begin
                ex_v_q  <= 1'b1;
                ex_wr_q <= id_reg_write_i;
                ex_ld_q <= id_mem_read_i;
                ex_rd_q <= id_rd_i;
            end else begin
                ex_v_q  <= 1'b0;
                ex_wr_q <= 1'b0;
                ex_ld_q <= 1'b0;
                ex_rd_q <= '0;
            end
            if (stall_o && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: per-cycle vector table through a
// scoreboard queue, plus hand sequences for reset mid-stall and counter saturation.
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_is_branch, id_is_jalr;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read, flush;
    logic [31:0] mem_alu_result;
    logic [1:0]  update;
    logic [31:0] forward;
    logic        stall;
    logic [31:0] stall_count;
    logic [1:0]  s_update;
    logic [31:0] s_forward;
    logic        s_stall;
    logic [1:0]  s_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
        .id_is_branch_i(id_is_branch), .id_is_jalr_i(id_is_jalr),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .flush_i(flush), .mem_alu_result_i(mem_alu_result),
        .update_o(update), .forward_o(forward), .stall_o(stall),
        .stall_count_o(stall_count)
    );

    // Narrow counter copy used only to observe saturation.
    branch_hazard_ctrl #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
        .id_is_branch_i(id_is_branch), .id_is_jalr_i(id_is_jalr),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .flush_i(flush), .mem_alu_result_i(mem_alu_result),
        .update_o(s_update), .forward_o(s_forward), .stall_o(s_stall),
        .stall_count_o(s_count)
    );

    typedef struct {
        logic        clr;
        logic        valid, br, jr;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, fl;
        logic [31:0] alu;
        logic [1:0]  eu;
        logic [31:0] ef;
        logic        es;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(int clr, int v, int br, int jr, int rs1, int rs2, int rd,
                                int rw, int mr, int fl, logic [31:0] alu, int eu,
                                logic [31:0] ef, int es, logic [31:0] ec);
        vec_t r;
        r.clr = (clr != 0); r.valid = (v != 0); r.br = (br != 0); r.jr = (jr != 0);
        r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.rw = (rw != 0); r.mr = (mr != 0); r.fl = (fl != 0);
        r.alu = alu; r.eu = 2'(eu); r.ef = ef; r.es = (es != 0); r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, got, want);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        logic [31:0] sat_want;
        @(negedge clk);
        if (v.clr) begin
            reset = 1'b1;
            #1;
            reset = 1'b0;
        end
        id_valid = v.valid; id_is_branch = v.br; id_is_jalr = v.jr;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_reg_write = v.rw; id_mem_read = v.mr; flush = v.fl;
        mem_alu_result = v.alu;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        sat_want = (e.ec > 32'd3) ? 32'd3 : e.ec;
        chk("update", idx, {30'b0, update}, {30'b0, e.eu});
        chk("forward", idx, forward, e.ef);
        chk("stall", idx, {31'b0, stall}, {31'b0, e.es});
        chk("stall_count", idx, stall_count, e.ec);
        chk("sat_count", idx, {30'b0, s_count}, sat_want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        id_valid = 0; id_is_branch = 0; id_is_jalr = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0; mem_alu_result = 0;
        #3;
        chk("reset_stall", 0, {31'b0, stall}, 32'd0);
        chk("reset_update", 0, {30'b0, update}, 32'd0);
        chk("reset_count", 0, stall_count, 32'd0);

        //          clr v br jr rs1 rs2 rd rw mr fl alu       eu ef        es ec
        // ALU producer then branch: stall, then forward rs1
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 5, 6, 0, 0, 0, 0, 'hAA,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 5, 6, 0, 0, 0, 0, 'hAA,     1, 'hAA,     0, 1));
        // load-use: two stall cycles
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h77,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h77,     0, 0,        1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h77,     0, 0,        0, 2));
        // same register on both operands, producer in MEM
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 9, 9, 0, 0, 0, 0, 'h1234,   0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 9, 9, 0, 0, 0, 0, 'h1234,   0, 0,        0, 1));
        // writes to x0 ignored in EX and MEM
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 'h55,     0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 'h55,     0, 0,        0, 0));
        // JALR ignores rs2; rs1 forwards from MEM
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0,       0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 3, 12, 1, 1, 0, 0, 'h99,    0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 12, 0, 0, 0, 0, 0, 'hCAFE,  1, 'hCAFE,   0, 0));
        // rs2-only forward
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 6, 0, 0, 0, 0, 'hBEEF,   2, 'hBEEF,   0, 0));
        // flush overrides a pending forward
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 6, 0, 0, 0, 1, 'hBEEF,   0, 0,        0, 0));
        // non-branch reading an EX producer never stalls
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4, 4, 5, 1, 0, 0, 'h11,     0, 0,        0, 0));
        // two writers of x8: EX (youngest) stalls, then forward
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8, 0, 0, 0, 0, 0, 'h88,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8, 0, 0, 0, 0, 0, 'h88,     1, 'h88,     0, 1));
        // load already in MEM: one stall
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2, 7, 0, 0, 0, 0, 'h70,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2, 7, 0, 0, 0, 0, 'h70,     0, 0,        0, 1));
        // flush on first load stall cycle; flushed x3 writer must not reach EX
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3, 7, 3, 1, 0, 1, 'h77,     0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 'h31,     0, 0,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 'h31,     0, 0,        0, 0));

        foreach (tbl[i]) apply(tbl[i], i + 1);

        // reset asserted between edges during the second load stall cycle
        apply(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0), 100);
        apply(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h5A, 0, 0, 1, 0), 101);
        apply(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h5A, 0, 0, 1, 1), 102);
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", 103, {31'b0, stall}, 32'd0);
        chk("rst_mid_update", 103, {30'b0, update}, 32'd0);
        chk("rst_mid_forward", 103, forward, 32'd0);
        chk("rst_mid_count", 103, stall_count, 32'd0);
        reset = 1'b0;
        apply(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h5A, 0, 0, 0, 0), 104);

        // repeated load-use to push the narrow counter past its maximum
        for (int r = 0; r < 3; r++) begin
            apply(mk((r == 0) ? 1 : 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 2 * r), 200 + 4 * r);
            apply(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h1, 0, 0, 1, 2 * r),     201 + 4 * r);
            apply(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h1, 0, 0, 1, 2 * r + 1), 202 + 4 * r);
            apply(mk(0, 1, 1, 0, 3, 7, 0, 0, 0, 0, 'h1, 0, 0, 0, 2 * r + 2), 203 + 4 * r);
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6), 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Generates the forward-select code, forward value and stall request that the ID-stage branch-operand forwarding mux consumes.
- Tracks in-flight register writers in a two-slot shadow scoreboard (EX, MEM) fed from decode.
- Resolves, in the same cycle, whether a branch or JALR in ID reads its operands from the register file, from a MEM-stage ALU result, or must stall.
- The register file is write-through, so WB-stage producers never need forwarding.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_is_branch  in  1  ID instruction is a conditional branch; uses rs1 and rs2
- id_is_jalr  in  1  ID instruction is JALR; uses rs1 only
- id_rs1  in  RA_W  ID source 1
- id_rs2  in  RA_W  ID source 2
- id_rd  in  RA_W  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction this cycle
- mem_alu_result  in  XLEN  ALU result of the instruction currently in MEM
- update  out  2  01 = forward to rs1, 10 = forward to rs2, 00 = none; 11 is never driven
- forward  out  XLEN  forwarded operand value
- stall  out  1  hold PC and IF/ID, insert a bubble into EX
- stall_count  out  CNT_W  number of cycles with stall = 1, saturating

Behaviour:

Reset and state
- Asynchronous reset clears both scoreboard slots (valid = 0) and stall_count to 0.
- While the slots are empty, outputs are update = 00, forward = 0, stall = 0.
- Each slot holds {valid, rd, wr, ld}.

Per rising edge
- MEM slot <= EX slot.
- EX slot <= {1, id_rd, id_reg_write, id_mem_read} when id_valid & ~stall & ~flush; otherwise a bubble (valid = 0).
- stall_count increments when stall = 1; it holds at all-ones.

Hazard evaluation (combinational, same cycle as ID)
- A source s is "used" when id_valid and either:
  - s = rs1 with id_is_branch or id_is_jalr, or
  - s = rs2 with id_is_branch.
- A used source with s = 0 is never hazardous.
- ex_hit(s) = EX.valid & EX.wr & EX.rd == s.
- mem_hit(s) = MEM.valid & MEM.wr & MEM.rd == s.
- If ex_hit on any used source: stall = 1.
  - ALU producer: 1 stall cycle.
  - Load producer: 2 stall cycles (it stalls again once the load is in MEM).
- If mem_hit with MEM.ld = 1: stall = 1.
- If mem_hit on rs1 only (MEM ALU): update = 01, forward = mem_alu_result, stall = 0.
- If mem_hit on rs2 only: update = 10, forward = mem_alu_result, stall = 0.
- If mem_hit on both used sources (rs1 == rs2): stall = 1 for one cycle, because the mux carries only one forward path. The next cycle the producer is in WB and no forward is needed.
- Any stall forces update = 00 and forward = 0.
- When no forward is active, forward = 0.
- EX hazards take priority over MEM forwarding. A source hit in both EX and MEM stalls, because the youngest writer wins.

Flush
- flush forces stall = 0, update = 00 and an EX bubble, regardless of hazards.
- A flush arriving during a multi-cycle load stall aborts the stall.
- stall_count does not increment in a flush cycle.

Other rules
- Non-branch instructions never raise stall or update; they are still recorded in the scoreboard.
- Reset asserted mid-stall clears the state immediately. The first cycle after reset deasserts has stall = 0.

Test Plan:
1. ALU producer, then branch one cycle later: `add x5` then `beq x5,x6` back to back; mem_alu_result = 0x0000_00AA. Expect:
   - cycle 0: stall = 1;
   - cycle 1: update = 01, forward = 0xAA, stall = 0.
2. Load-use on a branch: `lw x7` then `bne x3,x7`. Expect:
   - 2 cycles of stall = 1, then update = 00, stall = 0;
   - stall_count = 2.
3. Same register on both operands: `add x9` in MEM; ID `beq x9,x9`. Expect:
   - stall = 1 for 1 cycle, then update = 00;
   - update is never 11.
4. Writes to x0 and JALR rs2 are ignored:
   - `add x0` in MEM with ID `beq x0,x1` -> update = 00, stall = 0;
   - `jalr` whose rs2 field matches EX.rd -> stall = 0.
5. Flush during a load stall: assert flush on the first stall cycle. Expect:
   - stall = 0 that cycle, EX bubble;
   - stall_count unchanged;
   - no further stall.
6. Asynchronous reset mid-stall: assert reset between edges during a load stall. Expect:
   - stall, update and forward drop to 0 immediately;
   - stall_count = 0;
   - the scoreboard is empty after reset release.
